// File: rtl/qei_decoder_mc.sv
// Quadrature encoder decoder. Synchronises and de-glitches A/B/IDX, then decodes x1/x2/x4 counts.
// Also flags illegal A/B jumps and latches the position on index edges.
module qei_decoder_mc #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             idx_in,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             idx_clr_en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic [CNT_W-1:0] idx_latch,
    output logic             idx_seen
);
    localparam int FW       = $clog2(FILT_CYCLES + 1);
    localparam int INIT_LEN = SYNC_STAGES + FILT_CYCLES + 1;
    localparam int IW       = $clog2(INIT_LEN + 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               init_q, init_d;
    logic [2:0][SYNC_STAGES-1:0] sync_q;
    logic [2:0]                  sync_s;
    logic [2:0]                  filt_q, filt_d;
    logic [2:0][FW-1:0]          fcnt_q, fcnt_d;
    logic [1:0]                  prev_q, prev_d;
    logic                        idx_prev_q;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [CNT_W-1:0]            latch_q, latch_d;
    logic                        dir_q, dir_d;
    logic                        step_q, step_d;
    logic                        err_q, err_d;
    logic                        seen_q, seen_d;

    logic [2:0] pin;
    logic [1:0] ab_cur, pos_cur, pos_prev, delta;
    logic       fwd, bwd, ill, a_chg, cnt_en, idx_rise;

    // channel bit 2 = A, 1 = B, 0 = IDX
    assign pin    = {a_in, b_in, idx_in};
    assign sync_s = {sync_q[2][SYNC_STAGES-1], sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            if (state_q == ST_INIT) begin
                filt_d[ch] = sync_s[ch];
            end else if (sync_s[ch] != filt_q[ch]) begin
                if (fcnt_q[ch] == FW'(FILT_CYCLES - 1)) filt_d[ch] = sync_s[ch];
                else                                    fcnt_d[ch] = fcnt_q[ch] + FW'(1);
            end
        end
    end

    // Gray position 00,01,11,10 -> 0..3, so a forward step is +1 mod 4
    assign ab_cur   = filt_q[2:1];
    assign pos_cur  = {ab_cur[1], ^ab_cur};
    assign pos_prev = {prev_q[1], ^prev_q};
    assign delta    = pos_cur - pos_prev;
    assign fwd      = (delta == 2'd1);
    assign bwd      = (delta == 2'd3);
    assign ill      = (delta == 2'd2);
    assign a_chg    = ab_cur[1] ^ prev_q[1];
    assign idx_rise = (state_q == ST_RUN) && filt_q[0] && !idx_prev_q;

    always_comb begin
        case (mode)
            2'b01:   cnt_en = a_chg;
            2'b10:   cnt_en = a_chg & ab_cur[0];
            default: cnt_en = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        prev_d  = prev_q;
        count_d = count_q;
        latch_d = latch_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;
        seen_d  = seen_q;
        case (state_q)
            ST_INIT: begin
                if (init_q == '0) begin
                    state_d = ST_RUN;
                    prev_d  = filt_d[2:1];
                end else begin
                    init_d = init_q - IW'(1);
                end
            end
            default: begin
                prev_d = ab_cur;
                if (err_clr) err_d = 1'b0;
                if (ill)     err_d = 1'b1;
                if (fwd || bwd) begin
                    dir_d = fwd;
                    if (cnt_en) begin
                        count_d = fwd ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
                        step_d  = 1'b1;
                    end
                end
                if (idx_rise) begin
                    latch_d = count_q;
                    seen_d  = 1'b1;
                    if (idx_clr_en) begin
                        count_d = '0;
                        step_d  = 1'b0;
                    end
                end
            end
        endcase
        if (clr) begin
            count_d = '0;
            step_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_q     <= IW'(INIT_LEN - 1);
            sync_q     <= '0;
            filt_q     <= '0;
            fcnt_q     <= '0;
            prev_q     <= '0;
            idx_prev_q <= 1'b0;
            count_q    <= '0;
            latch_q    <= '0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
            err_q      <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            for (int ch = 0; ch < 3; ch++)
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], pin[ch]};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            prev_q     <= prev_d;
            idx_prev_q <= filt_q[0];
            count_q    <= count_d;
            latch_q    <= latch_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
        end
    end

    assign count     = count_q;
    assign dir       = dir_q;
    assign step      = step_q;
    assign err       = err_q;
    assign idx_latch = latch_q;
    assign idx_seen  = seen_q;
endmodule
